// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver (and its transmitter sibling).
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DELIVER,
        BREAK_WAIT
    } rx_state_t;

    // Parity mode encodings; any other value is treated as no parity.
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Width of a counter that must reach cpb-1; never narrower than one bit.
    function automatic int cnt_width(input int cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the level both stages take on reset (1 for an idle serial line).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity mode, stop bits and oversampling
// are fixed at elaboration. Words leave over a valid/ready handshake with per-word
// parity/framing flags; a word that finds the output still occupied is dropped and
// reported with a one-cycle overrun pulse.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int              CNT_W     = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0]      IDX_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      IDX_SLAST = 4'(STOP_BITS - 1);
    // Unknown parity modes fall back to no parity.
    localparam bit PAR_EN  = (PARITY_MODE == PARITY_EVEN) || (PARITY_MODE == PARITY_ODD);
    localparam bit PAR_ODD = (PARITY_MODE == PARITY_ODD);

    logic rxs;

    rx_state_t            state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [3:0]           idx_q,        idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 xor_q,        xor_d;
    logic                 perr_acc_q,   perr_acc_d;
    logic                 ferr_acc_q,   ferr_acc_d;
    logic [DATA_BITS-1:0] out_data_q,   out_data_d;
    logic                 out_valid_q,  out_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
    logic                 busy_q,       busy_d;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

    // Frame sequencing, bit sampling and output handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_d      = shift_q;
        xor_d        = xor_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        out_data_d   = out_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d    = START;
                    idx_d      = 4'd0;
                    xor_d      = 1'b0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // A start bit must still be low at its midpoint, else it was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // LSB arrives first; after DATA_BITS shifts it sits at bit 0.
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    xor_d   = xor_q ^ rxs;
                    if (idx_q == IDX_DLAST) begin
                        idx_d   = 4'd0;
                        state_d = PAR_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    perr_acc_d = PAR_ODD ? ((xor_q ^ rxs) != 1'b1) : ((xor_q ^ rxs) != 1'b0);
                    idx_d      = 4'd0;
                    state_d    = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        ferr_acc_d = 1'b1;
                    end else begin
                        ferr_acc_d = ferr_acc_q;
                    end
                    if (idx_q == IDX_SLAST) begin
                        state_d = DELIVER;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            DELIVER: begin
                // Load only if the output slot is free or being emptied this cycle.
                if (!out_valid_q || out_ready) begin
                    out_data_d   = shift_q;
                    parity_err_d = perr_acc_q;
                    frame_err_d  = ferr_acc_q;
                    out_valid_d  = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                // After a framing error wait for the line to recover (break guard).
                state_d = ferr_acc_q ? BREAK_WAIT : IDLE;
            end
            BREAK_WAIT: begin
                if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and registered outputs; reset abandons any frame and held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 4'd0;
            shift_q      <= '0;
            xor_q        <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            xor_q        <= xor_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) driven
// from a table of directed frames plus hand-written corner-case sequences.
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic rx_c = 1'b1;

    logic [7:0] a_data;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;
    logic [7:0] b_data;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;
    logic [6:0] c_data;
    logic       c_valid, c_perr, c_ferr, c_ovr, c_busy;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .out_data(a_data), .out_valid(a_valid),
        .out_ready(ready), .parity_err(a_perr), .frame_err(a_ferr),
        .overrun_err(a_ovr), .busy(a_busy));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .out_data(b_data), .out_valid(b_valid),
        .out_ready(ready), .parity_err(b_perr), .frame_err(b_ferr),
        .overrun_err(b_ovr), .busy(b_busy));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .rx_in(rx_c), .out_data(c_data), .out_valid(c_valid),
        .out_ready(ready), .parity_err(c_perr), .frame_err(c_ferr),
        .overrun_err(c_ovr), .busy(c_busy));

    // Handshake monitor: counts valid cycles, accepted words and overrun pulses.
    int         vc [3] = '{0, 0, 0};
    int         ac [3] = '{0, 0, 0};
    int         oc [3] = '{0, 0, 0};
    logic [8:0] cd [3] = '{9'd0, 9'd0, 9'd0};
    logic       cp [3] = '{1'b0, 1'b0, 1'b0};
    logic       cf [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clk) begin
        if (a_valid) vc[0] <= vc[0] + 1;
        if (a_valid && ready) begin
            ac[0] <= ac[0] + 1; cd[0] <= {1'b0, a_data}; cp[0] <= a_perr; cf[0] <= a_ferr;
        end
        if (a_ovr) oc[0] <= oc[0] + 1;
        if (b_valid) vc[1] <= vc[1] + 1;
        if (b_valid && ready) begin
            ac[1] <= ac[1] + 1; cd[1] <= {1'b0, b_data}; cp[1] <= b_perr; cf[1] <= b_ferr;
        end
        if (b_ovr) oc[1] <= oc[1] + 1;
        if (c_valid) vc[2] <= vc[2] + 1;
        if (c_valid && ready) begin
            ac[2] <= ac[2] + 1; cd[2] <= {2'b00, c_data}; cp[2] <= c_perr; cf[2] <= c_ferr;
        end
        if (c_ovr) oc[2] <= oc[2] + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int sel, input logic b);
        case (sel)
            0:       rx_a = b;
            1:       rx_b = b;
            default: rx_c = b;
        endcase
    endtask

    // Drives n bits LSB first, one bit per CPB clocks; the line is left at the last bit.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            tick(CPB);
        end
    endtask

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pbit;
        logic       stop_lo;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        vec_t       v;
        logic [15:0] bits;
        int         n;
        int         a0;
        int         v0;
        int         o0;

        //           sel data    p     stoplo data    perr  ferr
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vecs[3] = '{1, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h0A5, 1'b1, 1'b0, 9'h0A5, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h001, 1'b1, 1'b0, 9'h001, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h007, 1'b0, 1'b0, 9'h007, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h007, 1'b1, 1'b0, 9'h007, 1'b1, 1'b0};
        vecs[8] = '{2, 9'h000, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
        vecs[9] = '{2, 9'h055, 1'b0, 1'b1, 9'h055, 1'b1, 1'b1};

        // Reset state.
        tick(3);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_a_data",  {24'd0, a_data},  32'd0);
        chk("rst_a_busy",  {31'd0, a_busy},  32'd0);
        chk("rst_a_errs",  {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_c_valid", {31'd0, c_valid}, 32'd0);
        rst = 1'b0;
        tick(CPB);

        // Table-driven frames with out_ready held high.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            case (v.sel)
                0: begin
                    bits = {5'd0, ~v.stop_lo, v.data[7:0], 1'b0};
                    n = 10;
                end
                1: begin
                    bits = {5'd0, ~v.stop_lo, v.pbit, v.data[7:0], 1'b0};
                    n = 11;
                end
                default: begin
                    bits = {4'd0, 1'b1, ~v.stop_lo, v.pbit, v.data[6:0], 1'b0};
                    n = 11;
                end
            endcase
            a0 = ac[v.sel];
            v0 = vc[v.sel];
            send_bits(v.sel, bits, n);
            set_rx(v.sel, 1'b1);
            tick(2 * CPB);
            chk($sformatf("v%0d_count", i), ac[v.sel] - a0, 32'd1);
            chk($sformatf("v%0d_vcyc", i), vc[v.sel] - v0, 32'd1);
            chk($sformatf("v%0d_data", i), {23'd0, cd[v.sel]}, {23'd0, v.exp_data});
            chk($sformatf("v%0d_perr", i), {31'd0, cp[v.sel]}, {31'd0, v.exp_perr});
            chk($sformatf("v%0d_ferr", i), {31'd0, cf[v.sel]}, {31'd0, v.exp_ferr});
        end

        // Short low glitch: no word, busy falls back at mid start bit.
        a0 = ac[0];
        rx_a = 1'b0;
        tick(5);
        rx_a = 1'b1;
        chk("glitch_busy_hi", {31'd0, a_busy}, 32'd1);
        tick(11);
        chk("glitch_busy_lo", {31'd0, a_busy}, 32'd0);
        tick(2 * CPB);
        chk("glitch_no_word", ac[0] - a0, 32'd0);

        // Framing error followed by a held-low line, then a clean frame.
        a0 = ac[0];
        send_bits(0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10);
        tick(20 * CPB);
        chk("brk_count", ac[0] - a0, 32'd1);
        chk("brk_data",  {23'd0, cd[0]}, 32'h3C);
        chk("brk_ferr",  {31'd0, cf[0]}, 32'd1);
        chk("brk_busy",  {31'd0, a_busy}, 32'd1);
        rx_a = 1'b1;
        tick(2 * CPB);
        chk("brk_idle",  {31'd0, a_busy}, 32'd0);
        chk("brk_single", ac[0] - a0, 32'd1);
        send_bits(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10);
        rx_a = 1'b1;
        tick(2 * CPB);
        chk("brk_next_count", ac[0] - a0, 32'd2);
        chk("brk_next_data",  {23'd0, cd[0]}, 32'h55);
        chk("brk_next_ferr",  {31'd0, cf[0]}, 32'd0);

        // Overrun: consumer stalled across two frames.
        ready = 1'b0;
        a0 = ac[0];
        o0 = oc[0];
        send_bits(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10);
        rx_a = 1'b1;
        tick(CPB);
        send_bits(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10);
        rx_a = 1'b1;
        tick(2 * CPB);
        chk("ovr_valid", {31'd0, a_valid}, 32'd1);
        chk("ovr_held",  {24'd0, a_data}, 32'h11);
        chk("ovr_pulse", oc[0] - o0, 32'd1);
        ready = 1'b1;
        tick(2);
        chk("ovr_accept", ac[0] - a0, 32'd1);
        chk("ovr_acc_data", {23'd0, cd[0]}, 32'h11);
        chk("ovr_cleared", {31'd0, a_valid}, 32'd0);

        // Asynchronous reset mid-frame with a word held on the output.
        ready = 1'b0;
        send_bits(0, {6'd0, 1'b1, 8'hC3, 1'b0}, 10);
        rx_a = 1'b1;
        tick(CPB);
        chk("mid_held_valid", {31'd0, a_valid}, 32'd1);
        send_bits(0, 16'b0000_0000_0000_0010, 4);
        rx_a = 1'b0;
        tick(CPB / 2);
        chk("mid_busy_pre", {31'd0, a_busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_rst_data",  {24'd0, a_data}, 32'd0);
        chk("mid_rst_busy",  {31'd0, a_busy}, 32'd0);
        chk("mid_rst_errs",  {29'd0, a_perr, a_ferr, a_ovr}, 32'd0);
        rx_a = 1'b1;
        tick(2);
        rst = 1'b0;
        ready = 1'b1;
        tick(CPB);
        a0 = ac[0];
        send_bits(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10);
        rx_a = 1'b1;
        tick(2 * CPB);
        chk("post_rst_count", ac[0] - a0, 32'd1);
        chk("post_rst_data",  {23'd0, cd[0]}, 32'h81);
        chk("post_rst_errs",  {30'd0, cp[0], cf[0]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
